// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// the bit-timing helpers used to size the baud counter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    function automatic int clks_per_bit(input int clk_freq, input int bit_rate);
        return clk_freq / bit_rate;
    endfunction

    // Bits needed to hold values 0..max_count-1, never less than one.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Valid/ready byte stream between the UART receiver (master) and the
// command parser that consumes received bytes (slave).
interface uart_rx_fifo_if #(
    parameter int PAYLOAD_BITS = 8
);
    logic [PAYLOAD_BITS-1:0] rx_data;
    logic                    rx_valid;
    logic                    rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; a push while full is accepted only when a
// pop frees the head slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = wr_ptr_q - rd_ptr_q;

    // Head is forced to zero when empty so the output is deterministic.
    assign head_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, sticky error
// flags and a FWFT byte buffer. Define UART_RX_PARITY_EN for even parity.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BIT_RATE     = 115200,
    parameter int PAYLOAD_BITS = 8,
    parameter int BUFFER_SIZE  = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rx,
    uart_rx_fifo_if.master                bus,
    output logic                          frame_error,
    output logic                          overrun,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_error,
`endif
    input  logic                          error_clear,
    output logic [$clog2(BUFFER_SIZE):0]  fifo_count
);
    localparam int CPB = clks_per_bit(CLK_FREQ, BIT_RATE);
    localparam int CW  = cnt_width(CPB);
    localparam int IW  = cnt_width(PAYLOAD_BITS);

    localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [IW-1:0] LAST_BIT = IW'(PAYLOAD_BITS - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_e AFTER_DATA = PARITY;
`else
    localparam rx_state_e AFTER_DATA = STOP;
`endif

    logic                    rx_meta_q;
    logic                    rxs_q;
    rx_state_e               state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           bit_idx_q, bit_idx_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic                    frame_error_q, frame_error_d;
    logic                    overrun_q, overrun_d;
    logic                    push;
    logic                    frame_err_set;
    logic                    overrun_set;
    logic                    par_ok;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    fifo_pop;
    logic [PAYLOAD_BITS-1:0] fifo_head;

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
    logic parity_error_q, parity_error_d;
    logic par_err_set;
    assign par_ok = ~par_bad_q;
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = (cnt_q == CNT_FULL) ? '0 : cnt_q + CNT_ONE;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        push          = 1'b0;
        frame_err_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d     = par_bad_q;
        par_err_set   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
                if (!rxs_q) begin
                    state_d = START;
                end
            end
            START: begin
                // Re-check the line half a bit in to reject short glitches.
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rxs_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_FULL) begin
                    shift_d = {rxs_q, shift_q[PAYLOAD_BITS-1:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = AFTER_DATA;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_ONE;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    par_bad_d   = ^{shift_q, rxs_q};
                    par_err_set = ^{shift_q, rxs_q};
                    state_d     = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_FULL) begin
                    if (rxs_q) begin
                        push    = par_ok;
                        state_d = IDLE;
                    end else begin
                        frame_err_set = 1'b1;
                        state_d       = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held break stays here so it reports only one error.
                cnt_d = '0;
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign fifo_pop      = ~fifo_empty & bus.rx_ready;
    assign overrun_set   = push & fifo_full & ~fifo_pop;
    assign frame_error_d = frame_err_set | (frame_error_q & ~error_clear);
    assign overrun_d     = overrun_set | (overrun_q & ~error_clear);
`ifdef UART_RX_PARITY_EN
    assign parity_error_d = par_err_set | (parity_error_q & ~error_clear);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q     <= 1'b1;
            rxs_q         <= 1'b1;
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q      <= 1'b0;
            parity_error_q <= 1'b0;
`endif
        end else begin
            rx_meta_q     <= rx;
            rxs_q         <= rx_meta_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q      <= par_bad_d;
            parity_error_q <= parity_error_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    sync_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (BUFFER_SIZE)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (shift_q),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign bus.rx_data  = fifo_head;
    assign bus.rx_valid = ~fifo_empty;
    assign frame_error  = frame_error_q;
    assign overrun      = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error = parity_error_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 434 clocks per bit with a byte
// scoreboard; inputs change on the falling edge, outputs are read there too.
module tb_uart_rx_fifo;
    localparam int CLK_FREQ = 50000000;
    localparam int BIT_RATE = 115200;
    localparam int CPB      = CLK_FREQ / BIT_RATE;
    // Falling edges from stop-bit start to the cycle in which the byte is pushed:
    // 2 synchroniser stages + start detect + half-bit start check.
    localparam int PUSH_OFS = CPB / 2 + 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       error_clear = 1'b0;
    logic       frame_error;
    logic       overrun;
    logic [3:0] fifo_count;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo_if #(.PAYLOAD_BITS(8)) bus();

    uart_rx_fifo #(
        .CLK_FREQ     (CLK_FREQ),
        .BIT_RATE     (BIT_RATE),
        .PAYLOAD_BITS (8),
        .BUFFER_SIZE  (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx          (rx),
        .bus         (bus),
        .frame_error (frame_error),
        .overrun     (overrun),
        .error_clear (error_clear),
        .fifo_count  (fifo_count)
    );

    always #10 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, req);
        end
    endtask

    // Drive start + data + stop, returning on the falling edge of the push cycle.
    task automatic frame_to_push(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (PUSH_OFS) @(negedge clk);
    endtask

    task automatic frame_tail();
        repeat (CPB - PUSH_OFS) @(negedge clk);
    endtask

    task automatic drain(input int n, input string tag);
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check({tag, "_valid"}, bus.rx_valid, 1);
            check({tag, "_data"}, bus.rx_data, e);
            bus.rx_ready = 1'b1;
            @(negedge clk);
        end
        bus.rx_ready = 1'b0;
        check({tag, "_empty"}, bus.rx_valid, 0);
        check({tag, "_count0"}, fifo_count, 0);
    endtask

    initial begin
        bus.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.rx_valid, 0);
        check("rst_data", bus.rx_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ferr", frame_error, 0);
        check("rst_ovr", overrun, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte, consumer not ready
        frame_to_push(8'hA5, 1'b1);
        check("single_pre_valid", bus.rx_valid, 0);
        exp_q.push_back(8'hA5);
        @(negedge clk);
        check("single_valid", bus.rx_valid, 1);
        check("single_data", bus.rx_data, exp_q[0]);
        check("single_count", fifo_count, 1);
        check("single_ferr", frame_error, 0);
        check("single_ovr", overrun, 0);
        frame_tail();
        drain(1, "single");

        // Nine back-to-back bytes into an 8-deep buffer
        for (int v = 0; v < 9; v++) begin
            if (v < 8) exp_q.push_back(8'(v));
            frame_to_push(8'(v), 1'b1);
            frame_tail();
        end
        check("burst_count", fifo_count, 8);
        check("burst_ovr", overrun, 1);
        check("burst_ferr", frame_error, 0);
        error_clear = 1'b1;
        @(negedge clk);
        error_clear = 1'b0;
        check("burst_ovr_clr", overrun, 0);

        // Push into the full buffer in the same cycle as a pop
        frame_to_push(8'h09, 1'b1);
        check("fullpop_count_pre", fifo_count, 8);
        check("fullpop_head", bus.rx_data, exp_q.pop_front());
        exp_q.push_back(8'h09);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        check("fullpop_count", fifo_count, 8);
        check("fullpop_ovr", overrun, 0);
        frame_tail();
        drain(8, "fullpop");

        // Short low glitch
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (400) @(negedge clk);
        check("glitch_valid", bus.rx_valid, 0);
        check("glitch_count", fifo_count, 0);
        check("glitch_ferr", frame_error, 0);
        check("glitch_ovr", overrun, 0);

        // Framing error with a clear request in the same cycle, then a break
        frame_to_push(8'h3C, 1'b0);
        error_clear = 1'b1;
        @(negedge clk);
        error_clear = 1'b0;
        check("ferr_set_wins", frame_error, 1);
        check("ferr_count", fifo_count, 0);
        check("ferr_valid", bus.rx_valid, 0);
        frame_tail();
        repeat (2500) @(negedge clk);
        error_clear = 1'b1;
        @(negedge clk);
        error_clear = 1'b0;
        check("ferr_cleared", frame_error, 0);
        repeat (2500) @(negedge clk);
        check("break_single_err", frame_error, 0);
        check("break_count", fifo_count, 0);
        rx = 1'b1;
        repeat (20) @(negedge clk);

        exp_q.push_back(8'h7E);
        frame_to_push(8'h7E, 1'b1);
        frame_tail();
        check("after_break_valid", bus.rx_valid, 1);
        check("after_break_data", bus.rx_data, exp_q[0]);
        check("after_break_count", fifo_count, 1);
        check("after_break_ferr", frame_error, 0);

        // Reset during bit 4 of 0xFF while a byte is still buffered
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        check("midrst_valid", bus.rx_valid, 0);
        check("midrst_data", bus.rx_data, 0);
        check("midrst_count", fifo_count, 0);
        check("midrst_ferr", frame_error, 0);
        check("midrst_ovr", overrun, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        check("postrst_count", fifo_count, 0);

        exp_q.push_back(8'h55);
        frame_to_push(8'h55, 1'b1);
        frame_tail();
        drain(1, "postrst");
        check("postrst_ferr", frame_error, 0);
        check("postrst_ovr", overrun, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receive front end that sits directly upstream of the board controller's command parser. It feeds received bytes into it.
- Synchronises the raw rx pin, deserialises 8N1 frames using mid-bit sampling, and buffers bytes in a first-word-fall-through FIFO.
- Presents bytes on a valid/ready interface, and flags framing and overrun errors.
- Runs in the divided 50 MHz system clock domain, alongside the controller.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BIT_RATE, 115200: baud rate. CLKS_PER_BIT = CLK_FREQ/BIT_RATE with integer division, giving 434 at the defaults.
- PAYLOAD_BITS, 8: data bits per frame.
- BUFFER_SIZE, 8: FIFO depth in entries. Must be a power of two and at least 2.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- rx, input, 1: raw asynchronous UART line; idles high.
- rx_data, output, PAYLOAD_BITS: FIFO head byte.
- rx_valid, output, 1: FIFO non-empty.
- rx_ready, input, 1: consumer accepts the head byte.
- frame_error, output, 1: sticky flag; set on a stop bit sampled low.
- overrun, output, 1: sticky flag; set when a good byte arrives while the FIFO is full.
- error_clear, input, 1: clears both sticky flags.
- fifo_count, output, $clog2(BUFFER_SIZE)+1: number of occupied entries.

Behaviour:
- Reset values:
  - rx_data=0, rx_valid=0, frame_error=0, overrun=0, fifo_count=0.
  - Both synchroniser flops=1; FSM=IDLE; FIFO pointers=0.
- The asynchronous reset asserted mid-frame aborts the frame; no partial byte is ever written.
- rx passes through a 2-flop synchroniser. Only the synchronised value (rxs) is used.
- A baud counter runs from 0 to CLKS_PER_BIT-1. It is cleared on every state transition.
- FSM states and transitions:
  - IDLE: when rxs==0, go to START and clear the counter.
  - START: at count (CLKS_PER_BIT/2)-1, sample rxs.
    - rxs==1: glitch; return to IDLE.
    - rxs==0: go to DATA with bit index 0.
  - DATA: at count CLKS_PER_BIT-1, shift rxs in LSB-first. After PAYLOAD_BITS samples, go to STOP.
  - STOP: at count CLKS_PER_BIT-1, sample rxs.
    - rxs==1: push the byte and go to IDLE in the same cycle.
    - rxs==0: set frame_error, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs==1, then go to IDLE. A held break therefore produces exactly one frame_error and no bytes.
- Because all later samples are taken at mid-bit, the next start edge of a back-to-back frame is never missed.
- FIFO behaviour:
  - First-word-fall-through: rx_data equals the head entry whenever rx_valid==1. rx_data is don't-care when empty.
  - Pop occurs when rx_valid && rx_ready.
  - Latency: the push in the stop-sample cycle makes rx_valid high on the next cycle.
  - Push while full without a pop: byte dropped, overrun set, FIFO contents unchanged.
  - Push while full with a simultaneous pop: the push is accepted and fifo_count is unchanged.
  - Push while empty with rx_ready high: the byte appears one cycle later. There is no same-cycle bypass.
  - Pointers wrap modulo BUFFER_SIZE. fifo_count ranges 0..BUFFER_SIZE.
- Sticky flags:
  - error_clear clears both flags on the next edge.
  - If a set condition and error_clear occur in the same cycle, the set wins.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: a PARITY state follows DATA and samples one bit at mid-bit.
  - The parity is even: the XOR of data and parity must be 0.
  - On a mismatch the byte is discarded and a sticky parity_error output is set. parity_error resets to 0 and is cleared by error_clear.
  - Stop-bit handling is otherwise unchanged.
- Undefined: no PARITY state and no parity_error port; the frame format is 8N1.

Decomposition:
- Shared package/header uart_pkg:
  - FSM state encodings: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - CLKS_PER_BIT computation.
  - Counter-width helper.
- Sub-module sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports: push, push_data, pop, head_data, empty, full, count.
- The FSM, synchroniser and flags stay in uart_rx_fifo.

Test Plan:
- Single byte: send frame 0xA5 at 434 clk/bit with rx_ready=0. Required: rx_valid rises 1 cycle after the stop mid-sample, rx_data=0xA5, fifo_count=1, no error flags.
- Burst and overrun: send 9 back-to-back bytes 0x00..0x08 with rx_ready=0. Required: fifo_count=8 and overrun=1. Draining yields 0x00..0x07 in order and 0x08 is lost. error_clear then returns overrun to 0.
- Glitch rejection: 100-cycle low pulse on rx. Required: no byte, no flags, FSM back in IDLE.
- Framing error and break: byte 0x3C with the stop bit low, then rx held low for 5000 cycles. Required: frame_error=1, fifo_count=0. A following 0x7E frame is received correctly.
- Full with simultaneous pop: FIFO full, a push coincides with rx_ready=1. Required: fifo_count stays 8, no overrun, and the new byte appears last in drain order.
- Reset mid-frame: assert reset_n=0 during bit 4 of 0xFF. Required: all outputs take reset values, and a subsequent 0x55 frame is received cleanly.
